// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, frame
// defaults, parity types and the oversampling rates the receiver supports.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESCALE_W_DEF = 6;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic is_legal_prescale(input int prescale);
        return (prescale == PRESCALE_8) || (prescale == PRESCALE_16) ||
               (prescale == PRESCALE_32);
    endfunction

    function automatic logic expected_parity(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority voter around mid-bit: samples RX at H-1, H, H+1 and
// resolves the bit at H+2 (H = prescale/2), holding the result until the next vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_rx,
    input  logic [PRESCALE_W-1:0] i_edge_cnt,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_sampled_bit,
    output logic                  o_sample_done
);

    logic [PRESCALE_W-1:0] w_half;
    logic                  w_at_s0;
    logic                  w_at_s1;
    logic                  w_at_s2;
    logic                  w_at_vote;
    logic                  w_majority;

    logic [2:0]            r_samples;
    logic                  r_bit;

    assign w_half    = i_prescale >> 1;
    assign w_at_s0   = (i_edge_cnt == (w_half - PRESCALE_W'(1)));
    assign w_at_s1   = (i_edge_cnt == w_half);
    assign w_at_s2   = (i_edge_cnt == (w_half + PRESCALE_W'(1)));
    assign w_at_vote = (i_edge_cnt == (w_half + PRESCALE_W'(2)));

    assign w_majority = majority3(r_samples[0], r_samples[1], r_samples[2]);

    // NOTE: state is updated only with non-blocking assignments so every
    // register sees pre-edge values, independent of process evaluation order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_samples <= '0;
            r_bit     <= 1'b0;
        end else begin
            if (w_at_s0) r_samples[0] <= i_rx;
            if (w_at_s1) r_samples[1] <= i_rx;
            if (w_at_s2) r_samples[2] <= i_rx;
            if (w_at_vote) r_bit <= w_majority;
        end
    end

    // The vote is forwarded combinationally on its own cycle so the FSM can
    // act at H+2; afterwards the registered copy holds it for the rest of the bit.
    assign o_sample_done = w_at_vote;
    assign o_sampled_bit = w_at_vote ? w_majority : r_bit;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: start-bit detection, LSB-first deserialization, parity and
// stop checks, with registered one-cycle Data_Valid / Par_err / Stop_err strobes.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_err,
    output logic                  Stop_err
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    rx_state_e             r_state;
    rx_state_e             w_next_state;

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_mismatch;

    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stop_err;

    logic                  w_sampled_bit;
    logic                  w_sample_done;
    logic                  w_edge_last;
    logic                  w_last_bit;
    logic                  w_cfg_legal;
    logic                  w_start_frame;
    logic                  w_frame_done;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .i_rx          (RX_IN),
        .i_edge_cnt    (r_edge_cnt),
        .i_prescale    (r_prescale),
        .o_sampled_bit (w_sampled_bit),
        .o_sample_done (w_sample_done)
    );

    assign w_edge_last = (r_edge_cnt == (r_prescale - PRESCALE_W'(1)));
    assign w_last_bit  = (r_bit_cnt == LAST_BIT);
    assign w_cfg_legal = is_legal_prescale(int'(r_prescale));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state  = r_state;
        w_start_frame = 1'b0;
        w_frame_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!RX_IN) begin
                    w_next_state  = START;
                    w_start_frame = 1'b1;
                end
            end
            START: begin
                if (w_sample_done && w_sampled_bit) begin
                    w_next_state = IDLE;
                end else if (w_edge_last) begin
                    // An unsupported rate would only deserialize garbage; drop the frame.
                    w_next_state = w_cfg_legal ? DATA : IDLE;
                end
            end
            DATA: begin
                if (w_edge_last && w_last_bit) begin
                    w_next_state = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_edge_last) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_edge_last) begin
                    w_frame_done = 1'b1;
                    if (!RX_IN) begin
                        w_next_state  = START;
                        w_start_frame = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The cycle that detects the start edge is edge 0, so the counter
    // resumes at 1 when a frame begins.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
        end else if (w_start_frame) begin
            r_edge_cnt <= PRESCALE_W'(1);
        end else if (w_next_state == IDLE || w_edge_last) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt <= '0;
        end else if (r_state != DATA) begin
            r_bit_cnt <= '0;
        end else if (w_edge_last) begin
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_prescale <= '0;
        end else if (w_start_frame) begin
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_prescale <= Prescale;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift <= '0;
        end else if (r_state == DATA && w_sample_done) begin
            r_shift <= {w_sampled_bit, r_shift[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_mismatch <= 1'b0;
        end else if (w_start_frame) begin
            r_par_mismatch <= 1'b0;
        end else if (r_state == PARITY && w_sample_done) begin
            r_par_mismatch <= (expected_parity(^r_shift, r_par_typ) != w_sampled_bit);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stop_err   <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stop_err   <= 1'b0;
            if (w_frame_done) begin
                r_stop_err <= ~w_sampled_bit;
                r_par_err  <= r_par_en & r_par_mismatch;
                if (w_sampled_bit && !(r_par_en && r_par_mismatch)) begin
                    r_data_valid <= 1'b1;
                    r_p_data     <= r_shift;
                end
            end
        end
    end

    assign P_DATA     = r_p_data;
    assign Data_Valid = r_data_valid;
    assign Par_err    = r_par_err;
    assign Stop_err   = r_stop_err;

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Receive side of the UART link: oversamples RX_IN on the UART RX clock, detects the start bit, and deserializes an LSB-first frame.
- Frame format: start(0), DATA_WIDTH data bits, optional parity, stop(1).
- Checks parity and stop, then delivers P_DATA with a one-cycle Data_Valid strobe to the data-sync/system-control path.
- Frame format (PAR_EN/PAR_TYP) matches the TX side so the two ends interoperate.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of Prescale and of the edge counter.

Ports:
- CLK  input  1  RX oversampling clock.
- RST  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line, idle high; already synchronized upstream.
- PAR_EN  input  1  1 = parity bit present.
- PAR_TYP  input  1  0 = even, 1 = odd parity.
- Prescale  input  PRESCALE_W  CLK cycles per bit; legal values 8, 16, 32.
- P_DATA  output  DATA_WIDTH  last good received word.
- Data_Valid  output  1  one-cycle strobe, P_DATA valid.
- Par_err  output  1  one-cycle strobe, parity mismatch.
- Stop_err  output  1  one-cycle strobe, stop bit sampled 0.

Behaviour:
- Reset: all outputs 0; state IDLE; edge_cnt, bit_cnt, shift register and latched config cleared. Reset asserted mid-frame aborts the frame with no strobes.
- Config latch: PAR_EN, PAR_TYP and Prescale are latched on IDLE->START. Changes during a frame have no effect until the next frame. Illegal Prescale gives undefined data but the FSM must still return to IDLE.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit; at Prescale-1 it wraps to 0 and bit_cnt advances.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: RX_IN is sampled at edge_cnt = H-1, H, H+1 (H = Prescale/2). The bit value is the 2-of-3 majority, registered at edge_cnt = H+2.
- States:
  - IDLE: RX_IN=0 moves to START; that cycle counts as edge 0, so START is entered with edge_cnt=1.
  - START: if the sampled bit is 1 (glitch), go to IDLE at edge H+2 with no strobes. Otherwise, at edge Prescale-1 go to DATA.
  - DATA: the sampled bit is shifted in LSB-first, so the bit with bit_cnt=0 ends in P_DATA[0]. At edge Prescale-1 of bit DATA_WIDTH-1, go to PARITY if PAR_EN, else STOP.
  - PARITY: compute expected = XOR(data) XOR PAR_TYP and compare with the sampled bit; record a mismatch internally. At edge Prescale-1 go to STOP.
  - STOP: at edge Prescale-1, evaluate the frame:
    - stop sample 0 -> Stop_err=1;
    - parity mismatch -> Par_err=1 (both may assert together);
    - neither -> Data_Valid=1 and P_DATA loaded in the same cycle.
    Strobes are registered outputs, high for exactly one CLK cycle. Next state: START if RX_IN=0 in that cycle (back-to-back frames, edge_cnt=1), else IDLE.
- P_DATA holds its value between good frames. Errored frames never update P_DATA.
- Frame latency: last stop-bit edge to strobe = 1 CLK.
  - No parity: total 10×Prescale cycles, start edge to strobe.
  - With parity: 11×Prescale.

Decomposition:
- Shared package uart_pkg: state encoding (IDLE, START, DATA, PARITY, STOP), legal prescale constants (8/16/32), parity-type constants (EVEN=0, ODD=1), DATA_WIDTH default.
- One sub-module: uart_rx_sampler. It holds the 3-sample majority voter keyed on edge_cnt and Prescale, and outputs sampled_bit and sample_done.
- FSM, counters, deserializer and checks stay in uart_rx_fsm.

Test Plan:
1. Prescale=8, PAR_EN=0, send 0xA5 -> Data_Valid pulses once, 80 cycles after the start edge; P_DATA=0xA5; no errors.
2. Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> Data_Valid, P_DATA=0x3C. Resend with parity 1 -> Par_err pulse only; P_DATA stays 0x3C.
3. Prescale=32, PAR_TYP=1, send 0x01 with stop bit forced 0 -> Stop_err pulse, no Data_Valid. Line high afterwards -> FSM returns to IDLE.
4. Start glitch: RX_IN low for 3 cycles at Prescale=16 -> no strobes, FSM back in IDLE by edge 10, then a clean 0x5A frame is received.
5. Back-to-back frames 0x11 then 0x22 with no idle gap, Prescale=8 -> two Data_Valid pulses exactly 80 cycles apart, with correct data.
6. Reset mid-DATA (bit 4), then release and send 0xFF -> outputs 0 during reset, no strobe from the aborted frame, next frame P_DATA=0xFF.
